transmit_info: RTL

TRANSMIT_INFO -- requirements
Module: transmit_info

---
 rtl/info_pkg.sv | 21 ++
 rtl/info_piso_sr.sv | 22 ++
 rtl/transmit_info.sv | 96 +++++++++
 3 files changed

// File: rtl/info_pkg.sv
// Shared constants and state type for the info transmitter/receiver pair.
// Optional feature: define TRANSMIT_INFO_PARITY_EN to append one even-parity
// bit after mode (frame grows from 145 to 146 bits).
package info_pkg;
  localparam int KEY_BITS     = 128;
  localparam int ADDR_BITS    = 8;
  localparam int LOC_BITS     = 8;
  localparam int PAYLOAD_BITS = KEY_BITS + ADDR_BITS + LOC_BITS + 1;
`ifdef TRANSMIT_INFO_PARITY_EN
  localparam int FRAME_BITS   = PAYLOAD_BITS + 1;
`else
  localparam int FRAME_BITS   = PAYLOAD_BITS;
`endif
  localparam int CNT_BITS     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_t;
endpackage

// File: rtl/info_piso_sr.sv
// Parallel-load, MSB-first, serial-out shift register.
module info_piso_sr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_data,
  output logic         msb
);
  logic [W-1:0] sr;

  // Load has priority over shift; zeros fill from the bottom.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     sr <= '0;
    else if (load)  sr <= load_data;
    else if (shift) sr <= {sr[W-2:0], 1'b0};
  end

  assign msb = sr[W-1];
endmodule

// File: rtl/transmit_info.sv
// Serialises {key, address, location, mode} MSB first, one bit per clock.
// Build option TRANSMIT_INFO_PARITY_EN appends an even-parity bit over the
// payload.
module transmit_info
  import info_pkg::*;
(
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [KEY_BITS-1:0]  key,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [LOC_BITS-1:0]  location,
  input  logic                 mode,
  output logic                 serial_out,
  output logic                 shift_enable,
  output logic                 busy,
  output logic                 done
);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(FRAME_BITS - 1);

  tx_state_t                 state;
  logic [CNT_BITS-1:0]       cnt;
  logic [PAYLOAD_BITS-1:0]   payload;
  logic [FRAME_BITS-1:0]     frame_data;
  logic                      load;
  logic                      shift;
  logic                      sr_msb;

  assign payload = {key, address, location, mode};
`ifdef TRANSMIT_INFO_PARITY_EN
  assign frame_data = {payload, ^payload};
`else
  assign frame_data = payload;
`endif

  // Capture only when idle, so input changes mid-frame cannot leak in.
  assign load  = (state == IDLE) && start;
  assign shift = (state == SHIFT);

  info_piso_sr #(.W(FRAME_BITS)) u_sr (
    .clk       (clk),
    .n_rst     (n_rst),
    .load      (load),
    .shift     (shift),
    .load_data (frame_data),
    .msb       (sr_msb)
  );

  // Stale register contents never appear on the line outside a frame.
  assign serial_out = shift_enable & sr_msb;
  assign busy       = shift_enable;

  // Control FSM: IDLE -> SHIFT -> DONE -> IDLE, abort wins over completion.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      shift_enable <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= SHIFT;
            cnt          <= '0;
            shift_enable <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            state        <= IDLE;
            cnt          <= '0;
            shift_enable <= 1'b0;
          end else if (cnt == LAST_CNT) begin
            state        <= DONE;
            cnt          <= '0;
            shift_enable <= 1'b0;
            done         <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          cnt          <= '0;
          shift_enable <= 1'b0;
        end
      endcase
    end
  end
endmodule
